rns_mod_addsub_pipe: RTL and testbench
======================================

// Module: rns_mod_addsub_pipe
// PURPOSE
// Parametrised, pipelined modular add/subtract unit for one RNS residue channel.
// Computes (a - b) mod MODULUS or (a + b) mod MODULUS on residues of WIDTH bits.
// Uses a valid/ready handshake and a 2-stage pipeline with full backpressure.
// Successor to the fixed 12-bit two's-complement subtractor. One instance per RNS channel.
// PARAMETERS
// WIDTH    12    residue width in bits; MODULUS must fit: 2 <= MODULUS <= 2**WIDTH - 1
// MODULUS  4093  channel modulus m; legal operands are 0..m-1
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      asynchronous reset, active-high
// in_valid   in   1      operand beat present
// in_ready   out  1      unit accepts a beat this cycle
// op         in   1      0 = subtract (a-b) mod m, 1 = add (a+b) mod m
// a          in   WIDTH  operand residue
// b          in   WIDTH  operand residue
// out_valid  out  1      result beat present
// out_ready  in   1      downstream accepts the result this cycle
// result     out  WIDTH  modular result; 0 when err=1
// err        out  1      the accepted beat had a >= m or b >= m
// BEHAVIOUR
// - Reset (async, any time): s1_valid=0, s2_valid=0, out_valid=0, result=0, err=0. In-flight beats are discarded.
// - in_ready=1 after reset. Accept on in_valid & in_ready.
// - Stage 1 (register on accept):
//   - s1 holds op, range flag (a>=m | b>=m).
//   - raw = op ? a+b : a-b, computed at WIDTH+1 bits (borrow/carry kept in MSB).
// - Stage 2 correction:
//   - sub: borrow set -> raw + m, else raw.
//   - add: raw >= m -> raw - m, else raw.
//   - Result is truncated to WIDTH bits.
//   - Flagged beats: result=0, err=1.
// - Stall logic:
//   - adv2 = s1_valid & (!s2_valid | out_ready).
//   - in_ready = !s1_valid | adv2.
//   - No combinational path from in_valid to out_valid.
//   - Combinational path out_ready -> in_ready is allowed.
// - Latency 2 cycles from accept to out_valid when unstalled. Throughput 1 beat/cycle.
// - Holds:
//   - Hold on stall: result, err and out_valid stay stable while out_valid & !out_ready.
//   - out_valid stays high until consumed.
//   - When in_valid is low, the stage-1 registers hold their contents. Accepted beats are never dropped or duplicated; order is preserved.
// - Simultaneous accept and emit in the same cycle: both happen; occupancy is unchanged.
// - Capacity: 2 beats, one per stage. With out_ready low, in_ready falls after the 2nd accept.
// - Boundaries:
//   - a=b gives 0 for sub.
//   - a=0, b=m-1 sub gives 1.
//   - a=b=m-1 add gives m-2.
//   - op=1, a+b=m gives 0.
// TESTING (WIDTH=12, MODULUS=4093)
// - T1: sub a=100 b=30, out_ready=1 -> result=70, err=0, out_valid exactly 2 cycles after accept.
// - T2: sub a=30 b=100 -> 4023. Add a=4000 b=200 -> 107. Add a=4092 b=1 -> 0.
// - T3: a=4095 b=5 -> err=1, result=0. The next legal beat has err=0.
// - T4: stream 1000 random legal beats, in_valid and out_ready each randomised 50%.
//   - Expect: results match the reference model, in order, with no loss or duplication.
//   - Expect: result/err are stable during stalls.
// - T5: out_ready=0 and send 3 beats -> in_ready=0 after the 2nd accept. Release -> beats 1,2,3 come out in order.
// - T6: assert rst with 2 beats in flight -> out_valid=0 immediately. Nothing is emitted after release; in_ready=1.

Source files
------------

// File: rtl/rns_mod_addsub_pipe.sv
// Pipelined modular add/subtract for one RNS residue channel.
// Stage 1 registers the raw WIDTH+1 bit sum/difference; stage 2 folds it back into 0..m-1.
module rns_mod_addsub_pipe #(
    parameter int WIDTH   = 12,
    parameter int MODULUS = 4093
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [WIDTH-1:0] MOD_W   = WIDTH'(MODULUS);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic             s1_valid;
    logic             s1_op;
    logic             s1_flag;
    logic [WIDTH:0]   s1_raw;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_err;

    logic             adv2;
    logic             accept;
    logic [WIDTH:0]   raw_in;
    logic             flag_in;
    logic [WIDTH-1:0] corrected;

    assign adv2     = s1_valid & (!s2_valid | out_ready);
    assign in_ready = !s1_valid | adv2;
    assign accept   = in_valid & in_ready;

    assign raw_in  = op ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    assign flag_in = (a >= MOD_W) | (b >= MOD_W);

    // Both corrections are done at WIDTH bits: the true result is below 2**WIDTH,
    // so wrap-around in the low bits yields the right residue.
    always_comb begin
        corrected = s1_raw[WIDTH-1:0];
        if (s1_op) begin
            if (s1_raw >= MOD_EXT)
                corrected = s1_raw[WIDTH-1:0] - MOD_W;
        end else begin
            if (s1_raw[WIDTH])
                corrected = s1_raw[WIDTH-1:0] + MOD_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_flag  <= 1'b0;
            s1_raw   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_flag  <= flag_in;
            s1_raw   <= raw_in;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_err    <= 1'b0;
        end else if (adv2) begin
            s2_valid  <= 1'b1;
            s2_result <= s1_flag ? '0 : corrected;
            s2_err    <= s1_flag;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign err       = s2_err;

endmodule

// File: tb/tb_rns_mod_addsub_pipe.sv
// Directed-vector and streaming bench for rns_mod_addsub_pipe (WIDTH=12, MODULUS=4093).
module tb_rns_mod_addsub_pipe;

    localparam int W = 12;
    localparam int M = 4093;
    localparam int N_RAND = 1000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         err;

    int checks;
    int failures;

    rns_mod_addsub_pipe #(.WIDTH(W), .MODULUS(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic op;
        int   a;
        int   b;
        int   exp_r;
        logic exp_e;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input logic o, input int x, input int y);
        if (o) return (x + y) % M;
        return (x - y + M) % M;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int   exp_q[$];
    int   sent;
    int   got;
    int   cyc;
    logic held;
    int   held_r;
    logic held_e;
    int   t5_exp[3];
    int   idx;
    logic sent3;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;

        vecs[0]  = '{1'b0, 100,  30,   70,   1'b0};
        vecs[1]  = '{1'b0, 30,   100,  4023, 1'b0};
        vecs[2]  = '{1'b1, 4000, 200,  107,  1'b0};
        vecs[3]  = '{1'b1, 4092, 1,    0,    1'b0};
        vecs[4]  = '{1'b0, 555,  555,  0,    1'b0};
        vecs[5]  = '{1'b0, 0,    4092, 1,    1'b0};
        vecs[6]  = '{1'b1, 4092, 4092, 4091, 1'b0};
        vecs[7]  = '{1'b1, 2000, 2093, 0,    1'b0};
        vecs[8]  = '{1'b0, 4092, 0,    4092, 1'b0};
        vecs[9]  = '{1'b1, 4095, 5,    0,    1'b1};
        vecs[10] = '{1'b1, 7,    8,    15,   1'b0};
        vecs[11] = '{1'b0, 5,    4093, 0,    1'b1};
        vecs[12] = '{1'b0, 4093, 4093, 0,    1'b1};
        vecs[13] = '{1'b1, 0,    0,    0,    1'b0};

        step();
        step();
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset err", int'(err), 0);
        chk("reset in_ready", int'(in_ready), 1);
        rst = 1'b0;
        step();
        chk("post-reset in_ready", int'(in_ready), 1);

        // Directed vectors, one beat at a time, also checking 2-cycle latency.
        for (int i = 0; i < 14; i++) begin
            op = vecs[i].op;
            a = W'(vecs[i].a);
            b = W'(vecs[i].b);
            in_valid = 1'b1;
            chk($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid early", i), int'(out_valid), 0);
            step();
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d result", i), int'(result), vecs[i].exp_r);
            chk($sformatf("vec%0d err", i), int'(err), int'(vecs[i].exp_e));
            step();
            chk($sformatf("vec%0d drained", i), int'(out_valid), 0);
        end

        // Random streaming with backpressure.
        sent = 0;
        got = 0;
        cyc = 0;
        held = 1'b0;
        while (got < N_RAND && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            in_valid = (sent < N_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
            op = 1'($urandom_range(0, 1));
            a = W'($urandom_range(0, M - 1));
            b = W'($urandom_range(0, M - 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held) begin
                chk("stall out_valid", int'(out_valid), 1);
                chk("stall result", int'(result), held_r);
                chk("stall err", int'(err), int'(held_e));
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand unexpected beat", 1, 0);
                end else begin
                    chk($sformatf("rand beat%0d result", got), int'(result), exp_q.pop_front());
                    chk($sformatf("rand beat%0d err", got), int'(err), 0);
                end
                got++;
            end else if (out_valid) begin
                held = 1'b1;
                held_r = int'(result);
                held_e = err;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, int'(a), int'(b)));
                sent++;
            end
        end
        chk("rand all received", got, N_RAND);
        chk("rand queue empty", exp_q.size(), 0);

        // Capacity and ordered release under full backpressure.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        t5_exp[0] = 7;
        t5_exp[1] = 1;
        t5_exp[2] = 4092;
        op = 1'b0; a = 12'd10; b = 12'd3; in_valid = 1'b1;
        chk("t5 beat1 in_ready", int'(in_ready), 1);
        step();
        op = 1'b1; a = 12'd4092; b = 12'd2;
        chk("t5 beat2 in_ready", int'(in_ready), 1);
        step();
        op = 1'b0; a = 12'd0; b = 12'd1;
        chk("t5 full in_ready", int'(in_ready), 0);
        chk("t5 head out_valid", int'(out_valid), 1);
        step();
        chk("t5 still full", int'(in_ready), 0);
        chk("t5 head held", int'(result), 7);
        out_ready = 1'b1;
        idx = 0;
        sent3 = 1'b0;
        cyc = 0;
        while (idx < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                chk($sformatf("t5 order%0d", idx), int'(result), t5_exp[idx]);
                idx++;
            end
            if (in_valid && in_ready) sent3 = 1'b1;
            @(posedge clk);
            #1;
            if (sent3) in_valid = 1'b0;
        end
        chk("t5 three beats out", idx, 3);
        in_valid = 1'b0;
        step();
        step();
        chk("t5 drained", int'(out_valid), 0);

        // Async reset with two beats in flight.
        out_ready = 1'b0;
        op = 1'b1; a = 12'd1; b = 12'd2; in_valid = 1'b1;
        step();
        a = 12'd3;
        step();
        in_valid = 1'b0;
        chk("t6 occupied", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 out_valid on reset", int'(out_valid), 0);
        chk("t6 result on reset", int'(result), 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        held = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) held = 1'b1;
        end
        chk("t6 nothing emitted", int'(held), 0);
        chk("t6 in_ready", int'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
